sensor_board_scanner: RTL and testbench
=======================================

# sensor_board_scanner

Scans the 8-row x 4-column reed-switch matrix under the 32 playable squares of the checkers board. Drives one row at a time, samples the column returns through a synchronizer, and assembles a 32-bit occupancy frame. Debounces whole frames and presents a stable board word on `sensor_board`. That output feeds the memory manager's `sensorBoardIn`, which the CPU reads at address 0x1001.

## Interface
Parameters:
- `SETTLE_CYCLES`, 15: cycles each row is driven before sampling; legal range is 2 or more.
- `DEBOUNCE_FRAMES`, 3: number of consecutive identical frames required to commit; legal range is 1 or more.

Ports:
- `clock`  in  1: the single system clock. All logic is on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `scan_en`  in  1: scanning is enabled while high.
- `col_in`  in  4: raw matrix column returns; asynchronous; active-high means a piece is present.
- `row_sel`  out  8: one-hot row drive, or all-zero when idle.
- `sensor_board`  out  32: debounced occupancy. Bit `row*4+col` holds square (row, col).
- `board_valid`  out  1: high once the first frame has been committed.
- `board_changed`  out  1: one-cycle pulse when `sensor_board` updates.

## Operation
- Reset values:
  - `row_sel`=8'h00, `sensor_board`=0, `board_valid`=0, `board_changed`=0.
  - Row index 0, settle counter 0, frame buffer 0, `stable_cnt`=0, `prev_valid`=0.
  - FSM in IDLE.
- `col_in` passes through a 2-flop synchronizer. All sampling uses the synchronized value `col_s`.
- FSM states and transitions:
  - IDLE: `row_sel`=0. Goes to SETTLE with row 0 when `scan_en`=1.
  - SETTLE: `row_sel`=1<<row. Count 0..SETTLE_CYCLES-1, then go to SAMPLE.
  - SAMPLE (1 cycle): `row_sel` still 1<<row. Write `frame[row*4+:4]` <= `col_s`.
    - If row<7: row++, go to SETTLE.
    - If row==7: perform the frame-end actions below, row=0, go to SETTLE.
- Frame end (the SAMPLE cycle of row 7). Let `new_frame` = buffer with row 7 merged combinationally.
  - If `prev_valid` && `new_frame`==`prev_frame`: `stable_cnt` <= min(`stable_cnt`+1, DEBOUNCE_FRAMES-1). Otherwise `stable_cnt` <= 0.
  - `prev_frame` <= `new_frame`; `prev_valid` <= 1.
  - Commit occurs when the updated `stable_cnt` == DEBOUNCE_FRAMES-1 and (`new_frame` != `sensor_board` or !`board_valid`).
  - On commit: `sensor_board` <= `new_frame`, `board_valid` <= 1, `board_changed` <= 1 for exactly one cycle.
- A stable frame that equals `sensor_board` causes no pulse.
- `scan_en` deasserted mid-frame:
  - The next cycle goes to IDLE and `row_sel`=0.
  - The partial frame is discarded; the next frame restarts at row 0.
  - `prev_frame`, `stable_cnt`, and `sensor_board` are retained.
- `reset` mid-frame returns everything to reset values on the next edge. It overrides `scan_en`.

## Timing
- Row period is SETTLE_CYCLES+1 cycles. Frame period is 8*(SETTLE_CYCLES+1) cycles; with defaults, 128 cycles.
- Cycle 0 is the first cycle where `reset`=0 and `scan_en`=1 while in IDLE.
  - Cycle 0 is spent in IDLE. Row r is driven from cycle 1+r*(S+1) and sampled at cycle (r+1)*(S+1), where S=SETTLE_CYCLES.
  - Frame k ends at cycle 8k(S+1).
- Commit happens at the end of frame k. `sensor_board` and `board_changed` change on the following edge, visible one cycle after the frame-end SAMPLE cycle.
- First commit after reset occurs at the end of frame DEBOUNCE_FRAMES at the earliest.
- Synchronizer latency is 2 cycles. `SETTLE_CYCLES`>=2 guarantees `col_s` reflects the currently driven row.
- DEBOUNCE_FRAMES=1: every frame that differs from `sensor_board` commits, except the very first frame, which commits unconditionally.

## Structure
- Shared `checkers_pkg` / include file holds:
  - `NUM_ROWS`=8, `COLS_PER_ROW`=4, `BOARD_BITS`=32.
  - The address constant for the sensor register, 16'h1001.
  - The square-index function `row*4+col`.
- One sub-module, `sync_2ff` (parameterised width), synchronizes `col_in`. The FSM, frame buffer, and debounce logic stay in the top module.

## Test plan
Bench parameters: SETTLE_CYCLES=3, DEBOUNCE_FRAMES=3; frame = 32 cycles.
- Reset, then `scan_en`=1 with `col_in`=0.
  - All outputs are 0 through cycle 95.
  - `board_valid`=1 and `board_changed` pulses at the end of frame 3; `sensor_board`=0.
  - `row_sel` walks 01,02,...,80 with 4 cycles per row.
- Square mapping:
  - Drive `col_in`=4'b0100 only while row 5 is selected; expect `sensor_board`=32'h0040_0000 after 3 frames.
  - Full board: `col_in`=4'hF on all rows; expect 32'hFFFF_FFFF.
- Bounce: toggle a square in frames 1 and 3 only. There must be no commit until 3 identical consecutive frames are seen; the `board_changed` count must be exactly 1.
- Stable repeat: after commit, hold the same input for 10 frames. Expect no further `board_changed` pulses and `sensor_board` unchanged.
- `scan_en` low at row 4 of a frame:
  - `row_sel`=0 on the next cycle.
  - Re-enable: scanning restarts at row 0; the partial frame does not count toward `stable_cnt`.
- `reset` asserted mid-frame after a commit: all outputs return to 0 on the next edge, and the first commit takes 3 full frames again.

Source files
------------

// File: rtl/checkers_pkg.sv
// Shared checkers-board constants: matrix geometry, the CPU-visible sensor register
// address and the square-index mapping used by the board scanner.
package checkers_pkg;

    localparam int unsigned NUM_ROWS      = 8;
    localparam int unsigned COLS_PER_ROW  = 4;
    localparam int unsigned BOARD_BITS    = NUM_ROWS * COLS_PER_ROW;
    localparam logic [15:0] SENSOR_BOARD_ADDR = 16'h1001;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample
    } scan_state_e;

    function automatic int unsigned square_index(input int unsigned row,
                                                 input int unsigned col);
        return row * COLS_PER_ROW + col;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; each bit is synchronized
// independently.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/sensor_board_scanner.sv
// Row-at-a-time scanner for the 8x4 reed-switch matrix: builds 32-bit occupancy frames
// and commits a frame to sensor_board once it has been seen DEBOUNCE_FRAMES times in a row.
module sensor_board_scanner
    import checkers_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES   = 15,
    parameter int unsigned DEBOUNCE_FRAMES = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    scan_en,
    input  logic [COLS_PER_ROW-1:0] col_in,
    output logic [NUM_ROWS-1:0]     row_sel,
    output logic [BOARD_BITS-1:0]   sensor_board,
    output logic                    board_valid,
    output logic                    board_changed
);

    localparam int unsigned RW = $clog2(NUM_ROWS);
    localparam int unsigned SW = $clog2(SETTLE_CYCLES);
    localparam int unsigned CW = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;

    localparam logic [RW-1:0] LAST_ROW    = RW'(NUM_ROWS - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(DEBOUNCE_FRAMES - 1);

    scan_state_e           state_q, state_d;
    logic [RW-1:0]         row_q, row_d;
    logic [SW-1:0]         settle_q, settle_d;
    logic [BOARD_BITS-1:0] frame_q, frame_d;
    logic [BOARD_BITS-1:0] prev_frame_q, prev_frame_d;
    logic                  prev_valid_q, prev_valid_d;
    logic [CW-1:0]         stable_q, stable_d;
    logic [BOARD_BITS-1:0] board_q, board_d;
    logic                  valid_q, valid_d;
    logic                  changed_q, changed_d;

    logic [COLS_PER_ROW-1:0] col_s;
    logic [BOARD_BITS-1:0]   new_frame;
    logic [CW-1:0]           stable_upd;
    logic                    frame_match;
    logic                    commit;
    int unsigned             base;

    sync_2ff #(
        .WIDTH (COLS_PER_ROW)
    ) u_col_sync (
        .clock (clock),
        .reset (reset),
        .d     (col_in),
        .q     (col_s)
    );

    // Frame buffer with the currently sampled row merged in; only meaningful in StSample.
    always_comb begin
        base      = square_index(32'(row_q), 0);
        new_frame = frame_q;
        new_frame[base +: COLS_PER_ROW] = col_s;

        frame_match = prev_valid_q && (new_frame == prev_frame_q);
        if (!frame_match) begin
            stable_upd = '0;
        end else if (stable_q == STABLE_LAST) begin
            stable_upd = stable_q;
        end else begin
            stable_upd = stable_q + CW'(1);
        end

        commit = (stable_upd == STABLE_LAST) && ((new_frame != board_q) || !valid_q);
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        settle_d     = settle_q;
        frame_d      = frame_q;
        prev_frame_d = prev_frame_q;
        prev_valid_d = prev_valid_q;
        stable_d     = stable_q;
        board_d      = board_q;
        valid_d      = valid_q;
        changed_d    = 1'b0;
        row_sel      = '0;

        unique case (state_q)
            StIdle: begin
                if (scan_en) begin
                    state_d  = StSettle;
                    row_d    = '0;
                    settle_d = '0;
                end
            end
            StSettle: begin
                row_sel = NUM_ROWS'(1) << row_q;
                if (!scan_en) begin
                    state_d  = StIdle;
                    row_d    = '0;
                    settle_d = '0;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d  = StSample;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            StSample: begin
                row_sel = NUM_ROWS'(1) << row_q;
                if (!scan_en) begin
                    // Partial frame is dropped; debounce history is kept.
                    state_d  = StIdle;
                    row_d    = '0;
                    settle_d = '0;
                end else begin
                    state_d = StSettle;
                    frame_d = new_frame;
                    if (row_q == LAST_ROW) begin
                        row_d        = '0;
                        prev_frame_d = new_frame;
                        prev_valid_d = 1'b1;
                        stable_d     = stable_upd;
                        if (commit) begin
                            board_d   = new_frame;
                            valid_d   = 1'b1;
                            changed_d = 1'b1;
                        end
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                row_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            row_q        <= '0;
            settle_q     <= '0;
            frame_q      <= '0;
            prev_frame_q <= '0;
            prev_valid_q <= 1'b0;
            stable_q     <= '0;
            board_q      <= '0;
            valid_q      <= 1'b0;
            changed_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            settle_q     <= settle_d;
            frame_q      <= frame_d;
            prev_frame_q <= prev_frame_d;
            prev_valid_q <= prev_valid_d;
            stable_q     <= stable_d;
            board_q      <= board_d;
            valid_q      <= valid_d;
            changed_q    <= changed_d;
        end
    end

    assign sensor_board  = board_q;
    assign board_valid   = valid_q;
    assign board_changed = changed_q;

endmodule

// File: tb/tb_sensor_board_scanner.sv
// Bench for sensor_board_scanner: a matrix model answers row drives from a board pattern;
// expected commits are queued by the stimulus and checked by a separate pulse monitor.
module tb_sensor_board_scanner;

    logic        clock = 1'b0;
    logic        reset;
    logic        scan_en;
    logic [3:0]  col_in;
    logic [7:0]  row_sel;
    logic [31:0] sensor_board;
    logic        board_valid;
    logic        board_changed;

    logic [31:0] pattern;
    int cyc    = 0;
    int total  = 0;
    int bad    = 0;
    int npulse = 0;
    int start  = 0;
    int p0     = 0;

    typedef struct {
        logic [31:0] val;
        int          at;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    localparam logic [31:0] Y = 32'h8001_2400;

    sensor_board_scanner #(
        .SETTLE_CYCLES   (3),
        .DEBOUNCE_FRAMES (3)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .scan_en       (scan_en),
        .col_in        (col_in),
        .row_sel       (row_sel),
        .sensor_board  (sensor_board),
        .board_valid   (board_valid),
        .board_changed (board_changed)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Reed-switch matrix: the driven row returns its nibble of the board pattern.
    always_comb begin
        col_in = 4'h0;
        for (int r = 0; r < 8; r++) begin
            if (row_sel[r]) col_in = col_in | pattern[r*4 +: 4];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic expect_commit(input logic [31:0] v, input int at);
        exp_t e;
        e.val = v;
        e.at  = at;
        sb.push_back(e);
    endtask

    task automatic do_reset;
        reset   = 1'b1;
        scan_en = 1'b0;
        pattern = 32'h0;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic begin_scan;
        @(posedge clock);
        #1;
        scan_en = 1'b1;
        start   = cyc;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_row_sel"}, {24'h0, row_sel}, 32'h0);
        check({name, "_board"}, sensor_board, 32'h0);
        check({name, "_valid"}, {31'h0, board_valid}, 32'h0);
        check({name, "_changed"}, {31'h0, board_changed}, 32'h0);
    endtask

    always @(negedge clock) begin
        if (board_changed === 1'b1) begin
            npulse++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_change: got %h expected no change (cycle %0d)",
                         sensor_board, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("commit_value", sensor_board, mon_e.val);
                check("commit_cycle", cyc, mon_e.at);
                check("valid_at_commit", {31'h0, board_valid}, 32'h1);
            end
        end
    end

    initial begin
        reset   = 1'b1;
        scan_en = 1'b0;
        pattern = 32'h0;
        repeat (2) @(posedge clock);
        #1;

        // Empty board: walk, quiet outputs until the third frame commits.
        do_reset;
        @(negedge clock);
        check_all_zero("reset");
        begin_scan;
        expect_commit(32'h0, start + 97);
        for (int c = 0; c <= 96; c++) begin
            goto(start + c);
            @(negedge clock);
            check("row_walk", {24'h0, row_sel}, (c == 0) ? 32'h0 : (32'h1 << (((c - 1) / 4) % 8)));
            check("board_pre", sensor_board, 32'h0);
            check("valid_pre", {31'h0, board_valid}, 32'h0);
            check("changed_pre", {31'h0, board_changed}, 32'h0);
        end
        goto(start + 100);
        @(negedge clock);
        check("valid_post", {31'h0, board_valid}, 32'h1);

        // Ten more identical frames: no further pulses.
        goto(start + 97 + 320);
        @(negedge clock);
        check("stable_pulses", npulse, 1);
        check("stable_board", sensor_board, 32'h0);

        // Single square at row 5 col 2, then full board.
        do_reset;
        pattern = 32'h0040_0000;
        begin_scan;
        expect_commit(32'h0040_0000, start + 97);
        goto(start + 96);
        pattern = 32'hFFFF_FFFF;
        expect_commit(32'hFFFF_FFFF, start + 193);
        goto(start + 200);
        @(negedge clock);
        check("full_board", sensor_board, 32'hFFFF_FFFF);

        // Bounce: square present only in frames 1 and 3.
        do_reset;
        p0 = npulse;
        pattern = 32'h0000_1000;
        begin_scan;
        expect_commit(32'h0, start + 193);
        goto(start + 32);
        pattern = 32'h0;
        goto(start + 64);
        pattern = 32'h0000_1000;
        goto(start + 96);
        pattern = 32'h0;
        goto(start + 192);
        pattern = Y;
        @(negedge clock);
        check("bounce_no_early", {31'h0, board_valid}, 32'h0);
        goto(start + 200);
        @(negedge clock);
        check("bounce_pulses", npulse - p0, 1);
        check("bounce_board", sensor_board, 32'h0);

        // Frames 7,8 see Y; frame 9 is cut at row 4.
        goto(start + 273);
        @(negedge clock);
        check("row4_driven", {24'h0, row_sel}, 32'h10);
        scan_en = 1'b0;
        goto(start + 274);
        @(negedge clock);
        check("idle_after_disable", {24'h0, row_sel}, 32'h0);
        goto(start + 280);
        scan_en = 1'b1;
        start   = cyc;
        expect_commit(Y, start + 33);
        @(negedge clock);
        check("resume_idle", {24'h0, row_sel}, 32'h0);
        goto(start + 1);
        @(negedge clock);
        check("resume_row0", {24'h0, row_sel}, 32'h01);
        goto(start + 32);
        @(negedge clock);
        check("resume_pre_board", sensor_board, 32'h0);

        // Reset mid-frame after a commit.
        goto(start + 40);
        reset = 1'b1;
        goto(start + 41);
        reset = 1'b0;
        start = cyc;
        @(negedge clock);
        check_all_zero("mid_reset");
        expect_commit(Y, start + 97);
        goto(start + 96);
        @(negedge clock);
        check("reset_no_early", {31'h0, board_valid}, 32'h0);
        goto(start + 100);
        @(negedge clock);
        check("reset_recommit", sensor_board, Y);

        check("pending_commits", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
